// File: rtl/fp_round_pipe.sv
// ============================================================================
//  Module   : fp_round_pipe
//  Brief    : Two-stage normalise-and-round unit for the FP multiplier path.
//             Optional macro FP_ROUND_STICKY_FLAGS_EN adds sticky flag capture.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_round_pipe #(
    parameter int MAN_W = 23,
    parameter int EXP_W = 8,
    parameter int PW    = 2 * (MAN_W + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sign,
    input  logic [EXP_W+1:0]   in_exp,
    input  logic [PW-1:0]      in_prod,
    input  logic [1:0]         in_rmode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_sign,
    output logic [EXP_W-1:0]   out_exp,
    output logic [MAN_W-1:0]   out_man,
    output logic               out_inexact,
    output logic               out_overflow,
    output logic               out_underflow
`ifdef FP_ROUND_STICKY_FLAGS_EN
    ,
    input  logic               flag_clr,
    output logic [2:0]         sticky_flags
`endif
);

    // One extra exponent bit of headroom for the +1 normalise and +1 carry.
    localparam int XW = EXP_W + 3;

    localparam logic [1:0]      c_RNE     = 2'b00;
    localparam logic [1:0]      c_RTZ     = 2'b01;
    localparam logic [1:0]      c_RUP     = 2'b10;
    localparam logic [XW-2:0]   c_EXP_MAX = {2'b00, {EXP_W{1'b1}}};

    logic               w_adv;
    logic [PW-2:0]      w_norm;
    logic [XW-1:0]      w_exp1;

    logic               r_s1_valid;
    logic               r_s1_sign;
    logic [1:0]         r_s1_rmode;
    logic               r_s1_zero;
    logic [MAN_W-1:0]   r_s1_man;
    logic               r_s1_g;
    logic               r_s1_r;
    logic               r_s1_s;
    logic [XW-1:0]      r_s1_exp;

    logic               w_inc;
    logic               w_lost;
    logic [MAN_W:0]     w_sum;
    logic [XW-1:0]      w_exp2;
    logic               w_ovf_range;
    logic               w_unf_range;
    logic               w_to_inf;
    logic [EXP_W-1:0]   w_exp_o;
    logic [MAN_W-1:0]   w_man_o;
    logic               w_inx_o;
    logic               w_ovf_o;
    logic               w_unf_o;

    logic               r_out_valid;
    logic               r_out_sign;
    logic [EXP_W-1:0]   r_out_exp;
    logic [MAN_W-1:0]   r_out_man;
    logic               r_out_inexact;
    logic               r_out_overflow;
    logic               r_out_underflow;

    assign w_adv    = !r_out_valid | out_ready;
    assign in_ready = w_adv;

    // Drop the leading one: product in [2,4) keeps its alignment, [1,2) shifts up.
    assign w_norm = in_prod[PW-1] ? in_prod[PW-2:0] : {in_prod[PW-3:0], 1'b0};
    assign w_exp1 = {in_exp[EXP_W+1], in_exp} + {{(XW-1){1'b0}}, in_prod[PW-1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_rmode <= 2'b00;
            r_s1_zero  <= 1'b0;
            r_s1_man   <= '0;
            r_s1_g     <= 1'b0;
            r_s1_r     <= 1'b0;
            r_s1_s     <= 1'b0;
            r_s1_exp   <= '0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sign  <= in_sign;
                r_s1_rmode <= in_rmode;
                r_s1_zero  <= (in_prod == '0);
                r_s1_man   <= w_norm[PW-2 -: MAN_W];
                r_s1_g     <= w_norm[PW-2-MAN_W];
                r_s1_r     <= w_norm[PW-3-MAN_W];
                r_s1_s     <= |w_norm[PW-4-MAN_W:0];
                r_s1_exp   <= w_exp1;
            end
        end
    end

    always_comb begin
        w_inc = 1'b0;
        case (r_s1_rmode)
            c_RNE:   w_inc = r_s1_g & (r_s1_r | r_s1_s | r_s1_man[0]);
            c_RTZ:   w_inc = 1'b0;
            c_RUP:   w_inc = !r_s1_sign & (r_s1_g | r_s1_r | r_s1_s);
            default: w_inc =  r_s1_sign & (r_s1_g | r_s1_r | r_s1_s);
        endcase
    end

    assign w_lost = r_s1_g | r_s1_r | r_s1_s;
    assign w_sum  = {1'b0, r_s1_man} + {{MAN_W{1'b0}}, w_inc};
    // A carry out of the fraction leaves w_sum[MAN_W-1:0] at zero already.
    assign w_exp2 = r_s1_exp + {{(XW-1){1'b0}}, w_sum[MAN_W]};

    assign w_ovf_range = !w_exp2[XW-1] && (w_exp2[XW-2:0] >= c_EXP_MAX);
    assign w_unf_range = w_exp2[XW-1] || (w_exp2 == '0);
    assign w_to_inf    = (r_s1_rmode == c_RNE)
                       | ((r_s1_rmode == c_RUP) & !r_s1_sign)
                       | ((r_s1_rmode == 2'b11) &  r_s1_sign);

    always_comb begin
        w_exp_o = w_exp2[EXP_W-1:0];
        w_man_o = w_sum[MAN_W-1:0];
        w_inx_o = w_lost;
        w_ovf_o = 1'b0;
        w_unf_o = 1'b0;
        if (r_s1_zero) begin
            w_exp_o = '0;
            w_man_o = '0;
            w_inx_o = 1'b0;
        end else if (w_ovf_range) begin
            w_ovf_o = 1'b1;
            w_inx_o = 1'b1;
            w_exp_o = w_to_inf ? {EXP_W{1'b1}} : {{(EXP_W-1){1'b1}}, 1'b0};
            w_man_o = w_to_inf ? {MAN_W{1'b0}} : {MAN_W{1'b1}};
        end else if (w_unf_range) begin
            w_unf_o = 1'b1;
            w_inx_o = 1'b1;
            w_exp_o = '0;
            w_man_o = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid     <= 1'b0;
            r_out_sign      <= 1'b0;
            r_out_exp       <= '0;
            r_out_man       <= '0;
            r_out_inexact   <= 1'b0;
            r_out_overflow  <= 1'b0;
            r_out_underflow <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_sign      <= r_s1_sign;
                r_out_exp       <= w_exp_o;
                r_out_man       <= w_man_o;
                r_out_inexact   <= w_inx_o;
                r_out_overflow  <= w_ovf_o;
                r_out_underflow <= w_unf_o;
            end
        end
    end

    assign out_valid     = r_out_valid;
    assign out_sign      = r_out_sign;
    assign out_exp       = r_out_exp;
    assign out_man       = r_out_man;
    assign out_inexact   = r_out_inexact;
    assign out_overflow  = r_out_overflow;
    assign out_underflow = r_out_underflow;

`ifdef FP_ROUND_STICKY_FLAGS_EN
    logic [2:0] r_sticky;

    // Clear takes priority so a coincident result's flags are discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= 3'b000;
        end else if (flag_clr) begin
            r_sticky <= 3'b000;
        end else if (r_out_valid && out_ready) begin
            r_sticky <= r_sticky | {r_out_inexact, r_out_overflow, r_out_underflow};
        end
    end

    assign sticky_flags = r_sticky;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fp_round_pipe.sv
// ============================================================================
//  Module   : tb_fp_round_pipe
//  Brief    : Self-checking bench for fp_round_pipe against an arithmetic model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_round_pipe;

    localparam int MAN_W = 23;
    localparam int EXP_W = 8;
    localparam int PW    = 2 * (MAN_W + 1);
    localparam int RW    = MAN_W + EXP_W + 5;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic               in_sign;
    logic [EXP_W+1:0]   in_exp;
    logic [PW-1:0]      in_prod;
    logic [1:0]         in_rmode;
    logic               out_valid;
    logic               out_ready;
    logic               out_sign;
    logic [EXP_W-1:0]   out_exp;
    logic [MAN_W-1:0]   out_man;
    logic               out_inexact;
    logic               out_overflow;
    logic               out_underflow;
`ifdef FP_ROUND_STICKY_FLAGS_EN
    logic               flag_clr;
    logic [2:0]         sticky_flags;
`endif

    int tests = 0;
    int fails = 0;

    fp_round_pipe #(.MAN_W(MAN_W), .EXP_W(EXP_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sign       (in_sign),
        .in_exp        (in_exp),
        .in_prod       (in_prod),
        .in_rmode      (in_rmode),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_sign      (out_sign),
        .out_exp       (out_exp),
        .out_man       (out_man),
        .out_inexact   (out_inexact),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow)
`ifdef FP_ROUND_STICKY_FLAGS_EN
        ,
        .flag_clr      (flag_clr),
        .sticky_flags  (sticky_flags)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    function automatic logic [RW-1:0] cur_out();
        return {out_valid, out_sign, out_exp, out_man, out_inexact, out_overflow, out_underflow};
    endfunction

    // Reference: treat the product as an integer, divide by the ulp and
    // round the remainder by comparing against half an ulp.
    function automatic logic [RW-1:0] model(input logic s, input logic [EXP_W+1:0] e,
                                            input logic [PW-1:0] p, input logic [1:0] rm);
        longint          ex, maxe;
        longint unsigned pv, q, rem, half;
        int              k;
        logic            up, inx, ov, un, to_inf;
        logic [EXP_W-1:0] eo;
        logic [MAN_W-1:0] mo;
        if (p == '0) return {1'b1, s, {EXP_W{1'b0}}, {MAN_W{1'b0}}, 3'b000};
        ex = longint'($signed(e));
        pv = 64'(p);
        if (p[PW-1]) begin k = MAN_W + 1; ex = ex + 1; end
        else         k = MAN_W;
        q    = pv >> k;
        rem  = pv & ((64'd1 << k) - 1);
        half = 64'd1 << (k - 1);
        inx  = (rem != 0);
        case (rm)
            2'b00:   up = (rem > half) || (rem == half && q[0]);
            2'b01:   up = 1'b0;
            2'b10:   up = !s && inx;
            default: up = s && inx;
        endcase
        q = q + 64'(up);
        if (q == (64'd1 << (MAN_W + 1))) begin q = q >> 1; ex = ex + 1; end
        maxe = (64'sd1 <<< EXP_W) - 1;
        ov = 1'b0; un = 1'b0;
        to_inf = (rm == 2'b00) || (rm == 2'b10 && !s) || (rm == 2'b11 && s);
        if (ex >= maxe) begin
            ov = 1'b1; inx = 1'b1;
            eo = to_inf ? EXP_W'(maxe) : EXP_W'(maxe - 1);
            mo = to_inf ? '0 : '1;
        end else if (ex <= 0) begin
            un = 1'b1; inx = 1'b1; eo = '0; mo = '0;
        end else begin
            eo = EXP_W'(ex);
            mo = MAN_W'(q);
        end
        return {1'b1, s, eo, mo, inx, ov, un};
    endfunction

    task automatic send(input logic s, input logic [EXP_W+1:0] e, input logic [PW-1:0] p,
                        input logic [1:0] rm, output logic [RW-1:0] res, output int lat);
        @(negedge clk);
        in_valid = 1'b1; in_sign = s; in_exp = e; in_prod = p; in_rmode = rm;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        res = cur_out();
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        in_sign = 1'b1; in_exp = 10'd127; in_prod = 48'h8000_0000_0000; in_rmode = 2'b00;
`ifdef FP_ROUND_STICKY_FLAGS_EN
        flag_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        tests++;
        if (cur_out() !== '0) begin
            fails++; $display("FAIL reset_outputs got %h want 0", cur_out());
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_rne_tie;
        logic [RW-1:0] r, want; int l;
        send(1'b0, 10'd127, 48'h4000_0040_0000, 2'b00, r, l);
        want = {1'b1, 1'b0, 8'd127, 23'd0, 3'b100};
        tests++;
        if (r !== want) begin fails++; $display("FAIL rne_tie_even_down got %h want %h", r, want); end
        send(1'b0, 10'd127, 48'h4000_00C0_0000, 2'b00, r, l);
        want = {1'b1, 1'b0, 8'd127, 23'd2, 3'b100};
        tests++;
        if (r !== want) begin fails++; $display("FAIL rne_tie_even_up got %h want %h", r, want); end
        tests++;
        if (l != 2) begin fails++; $display("FAIL latency got %0d want 2", l); end
    endtask

    task automatic test_directed;
        logic [RW-1:0] r, want; int l;
        logic [1:0] modes [4] = '{2'b01, 2'b10, 2'b10, 2'b11};
        logic       signs [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [MAN_W-1:0] mans [4] = '{23'd0, 23'd1, 23'd0, 23'd1};
        for (int i = 0; i < 4; i++) begin
            send(signs[i], 10'd127, 48'h4000_0000_0001, modes[i], r, l);
            want = {1'b1, signs[i], 8'd127, mans[i], 3'b100};
            tests++;
            if (r !== want) begin
                fails++; $display("FAIL directed_mode%0d got %h want %h", i, r, want);
            end
        end
    endtask

    task automatic test_carry;
        logic [RW-1:0] r, want; int l;
        send(1'b0, 10'd127, 48'h7FFF_FFFF_FFFF, 2'b00, r, l);
        want = {1'b1, 1'b0, 8'd128, 23'd0, 3'b100};
        tests++;
        if (r !== want) begin fails++; $display("FAIL mantissa_carry got %h want %h", r, want); end
    endtask

    task automatic test_overflow;
        logic [RW-1:0] r, want; int l;
        send(1'b0, 10'd254, 48'h8000_0000_0000, 2'b00, r, l);
        want = {1'b1, 1'b0, 8'hFF, 23'd0, 3'b110};
        tests++;
        if (r !== want) begin fails++; $display("FAIL overflow_rne got %h want %h", r, want); end
        send(1'b0, 10'd254, 48'h8000_0000_0000, 2'b01, r, l);
        want = {1'b1, 1'b0, 8'hFE, 23'h7FFFFF, 3'b110};
        tests++;
        if (r !== want) begin fails++; $display("FAIL overflow_rtz got %h want %h", r, want); end
    endtask

    task automatic test_underflow_zero;
        logic [RW-1:0] r, want; int l;
        send(1'b1, 10'd0, 48'h4000_0000_0000, 2'b00, r, l);
        want = {1'b1, 1'b1, 8'd0, 23'd0, 3'b101};
        tests++;
        if (r !== want) begin fails++; $display("FAIL underflow got %h want %h", r, want); end
        send(1'b1, 10'd127, 48'h0, 2'b10, r, l);
        want = {1'b1, 1'b1, 8'd0, 23'd0, 3'b000};
        tests++;
        if (r !== want) begin fails++; $display("FAIL zero got %h want %h", r, want); end
    endtask

    task automatic test_random;
        logic [RW-1:0] r, want; int l, x;
        logic [PW-1:0] p; logic [EXP_W+1:0] e; logic s; logic [1:0] rm;
        for (int i = 0; i < 200; i++) begin
            x  = $urandom_range(0, 9);
            p  = PW'({$urandom, $urandom});
            if (x == 0)      p = '0;
            else if (x < 5)  p[PW-1] = 1'b1;
            else begin p[PW-1] = 1'b0; p[PW-2] = 1'b1; end
            x  = int'($urandom_range(0, 300)) - 20;
            e  = x[EXP_W+1:0];
            s  = 1'($urandom);
            rm = 2'($urandom);
            send(s, e, p, rm, r, l);
            want = model(s, e, p, rm);
            tests++;
            if (r !== want || l != 2) begin
                fails++;
                $display("FAIL random%0d prod=%h exp=%h rm=%0d got %h lat %0d want %h lat 2",
                         i, p, e, rm, r, l, want);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [RW-1:0] got[$];
        logic [RW-1:0] snap, cur;
        logic [PW-1:0] bp [4] = '{48'h4000_0040_0000, 48'h7FFF_FFFF_FFFF,
                                  48'h8000_0000_0003, 48'h5555_5555_5555};
        logic [EXP_W+1:0] be [4] = '{10'd100, 10'd127, 10'd60, 10'd200};
        logic [1:0] brm [4] = '{2'b00, 2'b00, 2'b10, 2'b11};
        logic bs [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic stalled = 1'b0, dropped = 1'b0;
        int sent = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            cur = cur_out();
            if (stalled) begin
                tests++;
                if (cur !== snap) begin
                    fails++; $display("FAIL stall_stable cyc%0d got %h want %h", cyc, cur, snap);
                end
            end
            out_ready = !(cyc >= 3 && cyc <= 5);
            if (sent < 4) begin
                in_valid = 1'b1; in_sign = bs[sent]; in_exp = be[sent];
                in_prod = bp[sent]; in_rmode = brm[sent];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            cur = cur_out();
            stalled = out_valid && !out_ready;
            snap = cur;
            if (in_valid && !in_ready) dropped = 1'b1;
            if (out_valid && out_ready) got.push_back(cur);
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tests++;
        if (dropped !== 1'b1) begin fails++; $display("FAIL b2b_in_ready_drop got 0 want 1"); end
        tests++;
        if (got.size() != 4) begin
            fails++; $display("FAIL b2b_count got %0d want 4", got.size());
        end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            tests++;
            if (got[i] !== model(bs[i], be[i], bp[i], brm[i])) begin
                fails++; $display("FAIL b2b_beat%0d got %h want %h", i, got[i],
                                  model(bs[i], be[i], bp[i], brm[i]));
            end
        end
    endtask

    task automatic test_reset_midflight;
        int seen = 0;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1;
        in_sign = 1'b0; in_exp = 10'd127; in_prod = 48'h8000_0000_0000; in_rmode = 2'b00;
        @(negedge clk);
        in_prod = 48'h4000_0000_0000;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_async got %b want 0", out_valid); end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_next_edge got %b want 0", out_valid); end
        rst_n = 1'b1; out_ready = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        tests++;
        if (seen != 0) begin fails++; $display("FAIL rst_flushed got %0d beats want 0", seen); end
    endtask

`ifdef FP_ROUND_STICKY_FLAGS_EN
    task automatic test_sticky;
        logic [RW-1:0] r; int l;
        @(negedge clk); flag_clr = 1'b1;
        @(negedge clk); flag_clr = 1'b0;
        tests++;
        if (sticky_flags !== 3'b000) begin fails++; $display("FAIL sticky_clr got %b want 000", sticky_flags); end
        send(1'b0, 10'd254, 48'h8000_0000_0000, 2'b01, r, l);
        @(negedge clk);
        tests++;
        if (sticky_flags !== 3'b110) begin fails++; $display("FAIL sticky_acc got %b want 110", sticky_flags); end
        flag_clr = 1'b1;
        @(negedge clk); flag_clr = 1'b0;
        tests++;
        if (sticky_flags !== 3'b000) begin fails++; $display("FAIL sticky_clr2 got %b want 000", sticky_flags); end
    endtask
`endif

    initial begin
        test_reset();
        test_rne_tie();
        test_directed();
        test_carry();
        test_overflow();
        test_underflow_zero();
        test_random();
        test_back_to_back();
        test_reset_midflight();
`ifdef FP_ROUND_STICKY_FLAGS_EN
        test_sticky();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
